// File: rtl/cpu_pkg.sv
// Shared core definitions: fetch widths, reset vector, fetch-queue entry layout and fetch FSM states.
package cpu_pkg;

   localparam int               ADDR_W   = 16;
   localparam int               INSTR_W  = 16;
   localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_WAIT_ACK  = 2'b01,
      ST_WAIT_DROP = 2'b10
   } fetch_state_e;

   // Sequential PC; wraps from the top of the address space back to zero
   function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
      return pc + {{(ADDR_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory port, execute redirect and decode handshake.
interface instr_fetch_queue_if;
   import cpu_pkg::*;

   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;
   logic               redirect;
   logic [ADDR_W-1:0]  redirect_pc;
   logic               instr_valid;
   logic [INSTR_W-1:0] instr;
   logic [ADDR_W-1:0]  instr_pc;
   logic               instr_ready;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc,
      input  imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc,
      output imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush and occupancy output; head word is a registered-storage view.
module sync_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 32,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;

   // Storage, pointers and occupancy; flush empties the queue and overrides push/pop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push) begin
            mem_r[wr_ptr_r] <= wdata;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         count_r <= count_r + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
      end
   end

   assign rdata = mem_r[rd_ptr_r];
   assign count = count_r;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: single-outstanding imem reads buffered as {pc, instr} in a prefetch FIFO, flushed on redirect.
// Build macro FETCH_STALL_CNT_EN adds the saturating stall_cnt output (cycles with an empty queue).
module instr_fetch_queue
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
`ifdef FETCH_STALL_CNT_EN
   output logic [15:0]         stall_cnt,
`endif
   instr_fetch_queue_if.master fq
);

   localparam int               CNT_W     = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   fetch_state_e      state_r;
   fetch_state_e      state_nxt_s;
   logic [ADDR_W-1:0] fetch_pc_r;
   logic [ADDR_W-1:0] fetch_pc_nxt_s;
   logic [ADDR_W-1:0] addr_r;
   logic              req_r;
   logic              new_req_s;
   logic              push_s;
   logic              pop_s;
   logic              flush_s;
   logic [CNT_W-1:0]  count_s;
   logic [CNT_W-1:0]  count_nxt_s;
   fetch_entry_t      wr_entry_s;
   fetch_entry_t      rd_entry_s;

   // Only an ack to a live (non-dropped) request is queued; redirect cancels both push and pop
   assign flush_s          = fq.redirect;
   assign pop_s            = (count_s != {CNT_W{1'b0}}) && fq.instr_ready && !fq.redirect;
   assign push_s           = (state_r == ST_WAIT_ACK) && fq.imem_ack && !fq.redirect;
   assign wr_entry_s.pc    = addr_r;
   assign wr_entry_s.instr = fq.imem_rdata;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush_s),
      .push  (push_s),
      .pop   (pop_s),
      .wdata (wr_entry_s),
      .rdata (rd_entry_s),
      .count (count_s)
   );

   // Queue occupancy after this edge, used to decide whether another request fits
   always_comb begin
      count_nxt_s = count_s;
      if (flush_s) begin
         count_nxt_s = {CNT_W{1'b0}};
      end else begin
         count_nxt_s = count_s + {{(CNT_W-1){1'b0}}, push_s} - {{(CNT_W-1){1'b0}}, pop_s};
      end
   end

   // Next fetch PC, next FSM state and whether a fresh request address is launched
   always_comb begin
      state_nxt_s    = state_r;
      fetch_pc_nxt_s = fetch_pc_r;
      new_req_s      = 1'b0;

      if (fq.redirect) begin
         fetch_pc_nxt_s = fq.redirect_pc;
      end else if (push_s) begin
         fetch_pc_nxt_s = pc_incr(fetch_pc_r);
      end else begin
         fetch_pc_nxt_s = fetch_pc_r;
      end

      case (state_r)
         ST_IDLE: begin
            if (count_nxt_s < DEPTH_CNT) begin
               state_nxt_s = ST_WAIT_ACK;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT_ACK: begin
            if (fq.imem_ack) begin
               if (count_nxt_s < DEPTH_CNT) begin
                  state_nxt_s = ST_WAIT_ACK;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end else if (fq.redirect) begin
               // Request already on the bus: keep it until the ack and throw the word away
               state_nxt_s = ST_WAIT_DROP;
            end else begin
               state_nxt_s = ST_WAIT_ACK;
            end
         end
         ST_WAIT_DROP: begin
            if (fq.imem_ack) begin
               state_nxt_s = ST_WAIT_ACK;
            end else begin
               state_nxt_s = ST_WAIT_DROP;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase

      if ((state_nxt_s == ST_WAIT_ACK) && ((state_r != ST_WAIT_ACK) || fq.imem_ack)) begin
         new_req_s = 1'b1;
      end else begin
         new_req_s = 1'b0;
      end
   end

   // Fetch FSM, fetch PC and the registered imem request/address
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         fetch_pc_r <= RESET_PC;
         addr_r     <= RESET_PC;
         req_r      <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         fetch_pc_r <= fetch_pc_nxt_s;
         req_r      <= (state_nxt_s != ST_IDLE);
         if (new_req_s) begin
            addr_r <= fetch_pc_nxt_s;
         end
      end
   end

   assign fq.imem_req    = req_r;
   assign fq.imem_addr   = addr_r;
   assign fq.instr_valid = (count_s != {CNT_W{1'b0}});
   assign fq.instr       = rd_entry_s.instr;
   assign fq.instr_pc    = rd_entry_s.pc;

`ifdef FETCH_STALL_CNT_EN
   logic [15:0] stall_cnt_r;

   // Saturating count of cycles with nothing to hand to decode
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_r <= 16'h0000;
      end else if ((count_s == {CNT_W{1'b0}}) && (stall_cnt_r != 16'hFFFF)) begin
         stall_cnt_r <= stall_cnt_r + 16'h0001;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomised bench for instr_fetch_queue: a queue-level reference model driven by a random-latency memory.
module tb_instr_fetch_queue;
   import cpu_pkg::*;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] ins;
   } ent_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   instr_fetch_queue_if fq ();
`ifdef FETCH_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   instr_fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
`ifdef FETCH_STALL_CNT_EN
      .stall_cnt (stall_cnt),
`endif
      .fq        (fq)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   ent_t        q[$];
   logic [15:0] popped[$];
   logic [15:0] m_pc;
   logic [15:0] prev_addr;
   logic [15:0] redir_target;
   bit          m_stale, in_req, prev_req_noack, hold_ack, fired;
   int          wait_left, npops, base, first;
   int          ready_pct, lat_min, lat_max, stray_pct, redir_permille, redir_mode;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'hC35A;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: compare DUT to the model, drive random inputs, advance the model
   task automatic step();
      bit          do_ack, do_rdy, do_rd, pop;
      logic [15:0] rpc;
      @(negedge clk);
      check("valid", 32'(fq.instr_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         check("head_pc", 32'(fq.instr_pc), 32'(q[0].pc));
         check("head_instr", 32'(fq.instr), 32'(q[0].ins));
      end
      if (q.size() == DEPTH) check("req_when_full", 32'(fq.imem_req), 32'd0);
      if (prev_req_noack) begin
         check("req_hold", 32'(fq.imem_req), 32'd1);
         check("addr_hold", 32'(fq.imem_addr), 32'(prev_addr));
      end

      do_rdy = ($urandom_range(0, 99) < ready_pct);
      do_ack = 1'b0;
      if (fq.imem_req) begin
         if (!in_req) begin
            in_req    = 1'b1;
            wait_left = int'($urandom_range(lat_min, lat_max));
         end
         if (hold_ack) do_ack = 1'b0;
         else if (wait_left == 0) do_ack = 1'b1;
         else wait_left--;
      end else begin
         in_req = 1'b0;
         do_ack = ($urandom_range(0, 99) < stray_pct);
      end

      do_rd = 1'b0;
      rpc   = 16'($urandom);
      case (redir_mode)
         0: begin
            do_rd = ($urandom_range(0, 999) < redir_permille);
            if ($urandom_range(0, 3) == 0) rpc = 16'hFFFC + 16'($urandom_range(0, 3));
         end
         1: if (fq.imem_req && !do_ack) begin do_rd = 1'b1; rpc = redir_target; end
         2: if (fq.imem_req && do_ack && q.size() != 0 && do_rdy) begin do_rd = 1'b1; rpc = redir_target; end
         4: begin do_rd = 1'b1; rpc = redir_target; end
         default: do_rd = 1'b0;
      endcase
      if (do_rd && redir_mode != 0) begin
         fired      = 1'b1;
         redir_mode = 3;
      end

      fq.imem_ack    = do_ack;
      fq.imem_rdata  = do_ack ? mem_word(fq.imem_addr) : 16'($urandom);
      fq.instr_ready = do_rdy;
      fq.redirect    = do_rd;
      fq.redirect_pc = rpc;

      if (fq.imem_req && do_ack) in_req = 1'b0;
      pop = (q.size() != 0) && do_rdy && !do_rd;
      if (pop) begin
         popped.push_back(q[0].pc);
         void'(q.pop_front());
         npops++;
      end
      if (do_rd) begin
         q.delete();
         m_pc    = rpc;
         m_stale = fq.imem_req && !do_ack;
      end else if (fq.imem_req && do_ack) begin
         if (m_stale) begin
            m_stale = 1'b0;
         end else begin
            check("fetch_addr", 32'(fq.imem_addr), 32'(m_pc));
            q.push_back('{pc: m_pc, ins: mem_word(m_pc)});
            m_pc = m_pc + 16'h0001;
         end
      end
      prev_req_noack = fq.imem_req && !do_ack;
      prev_addr      = fq.imem_addr;
   endtask

   // Reset with reset-state checks; ack is left high across release as a stray strobe
   task automatic do_reset();
      @(negedge clk);
      reset          = 1'b1;
      fq.imem_ack    = 1'b1;
      fq.imem_rdata  = 16'hDEAD;
      fq.redirect    = 1'b0;
      fq.redirect_pc = 16'h0000;
      fq.instr_ready = 1'b0;
      #1;
      check("rst_req", 32'(fq.imem_req), 32'd0);
      check("rst_valid", 32'(fq.instr_valid), 32'd0);
      check("rst_instr", 32'(fq.instr), 32'd0);
      check("rst_pc", 32'(fq.instr_pc), 32'd0);
      q.delete();
      popped.delete();
      m_pc = RESET_PC; m_stale = 1'b0; in_req = 1'b0; prev_req_noack = 1'b0;
      fired = 1'b0; redir_mode = 3;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      hold_ack = 1'b0; stray_pct = 0; redir_permille = 0; npops = 0;
      ready_pct = 100; lat_min = 0; lat_max = 0;

      // Single-cycle memory, decode always ready
      do_reset();
      first = -1;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (fq.instr_valid && first < 0) first = i;
      end
      check("first_valid_cycle", 32'(first), 32'd2);
      check("t1_pops", 32'(popped.size() >= 3), 32'd1);
      for (int i = 0; i < 3; i++) if (i < popped.size()) check("t1_seq_pc", 32'(popped[i]), 32'(i));

      // Decode stalled: fill exactly DEPTH, then drain in order
      do_reset();
      ready_pct = 0; lat_max = 1;
      repeat (15) step();
      check("t2_req_full", 32'(fq.imem_req), 32'd0);
      check("t2_valid_full", 32'(fq.instr_valid), 32'd1);
      hold_ack = 1'b1; ready_pct = 100; base = npops;
      repeat (10) step();
      check("t2_drain_count", 32'(npops - base), 32'd4);
      for (int i = 0; i < 4; i++) if (i < popped.size()) check("t2_drain_pc", 32'(popped[i]), 32'(i));
      hold_ack = 1'b0;

      // Redirect while a 3-cycle fetch is outstanding
      do_reset();
      lat_min = 2; lat_max = 2;
      repeat (8) step();
      redir_target = 16'h0040; redir_mode = 1;
      for (int i = 0; i < 20 && !fired; i++) step();
      check("t3_fired", 32'(fired), 32'd1);
      step();
      check("t3_flushed", 32'(fq.instr_valid), 32'd0);
      for (int i = 0; i < 30 && !fq.instr_valid; i++) step();
      check("t3_new_pc", 32'(fq.instr_pc), 32'h0040);

      // Redirect coinciding with ack and pop
      do_reset();
      lat_min = 0; lat_max = 0;
      repeat (5) step();
      redir_target = 16'h1234; redir_mode = 2;
      for (int i = 0; i < 20 && !fired; i++) step();
      check("t4_fired", 32'(fired), 32'd1);
      step();
      check("t4_flushed", 32'(fq.instr_valid), 32'd0);
      for (int i = 0; i < 30 && !fq.instr_valid; i++) step();
      check("t4_new_pc", 32'(fq.instr_pc), 32'h1234);

      // PC wrap across the top of the address space
      do_reset();
      lat_max = 2;
      repeat (6) step();
      redir_target = 16'hFFFE; redir_mode = 4;
      step();
      popped.delete();
      for (int i = 0; i < 60 && popped.size() < 3; i++) step();
      check("t5_pops", 32'(popped.size() >= 3), 32'd1);
      if (popped.size() >= 3) begin
         check("t5_pc0", 32'(popped[0]), 32'h0000FFFE);
         check("t5_pc1", 32'(popped[1]), 32'h0000FFFF);
         check("t5_pc2", 32'(popped[2]), 32'h00000000);
      end

      // Random traffic, each segment starting from a reset that may cut a fetch short
      for (int seg = 0; seg < 6; seg++) begin
         do_reset();
         ready_pct = int'($urandom_range(10, 100));
         lat_min = 0; lat_max = int'($urandom_range(0, 3));
         stray_pct = 10; redir_permille = 40; redir_mode = 0;
         base = npops;
         repeat (500) step();
         check("progress", 32'(npops > base), 32'd1);
      end
      stray_pct = 0; redir_mode = 3;

`ifdef FETCH_STALL_CNT_EN
      do_reset();
      hold_ack = 1'b1;
      repeat (5) step();
      check("stall_cnt_5", 32'(stall_cnt), 32'd5);
      reset = 1'b1;
      #1;
      check("stall_cnt_rst", 32'(stall_cnt), 32'd0);
      hold_ack = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
